cg_vector_bank: RTL and testbench
=================================

// Module: cg_vector_bank
// PURPOSE
//  Double-buffered vector store on the ALU's result side. It receives the beats that the CG ALU writes
//  (memoryX/R/P_input, qualified by result_mem_we_*). It serves the next iteration's reads as
//  rKold/xKold/pKold_v2 beats on read pulses (read_again / outsider_read).
//  The write bank fills while the read bank is drained. A swap pulse at iteration end
//  (mul_add3_finish) exchanges the two banks. One instance is used per vector: x, r and p.
// PARAMETERS
//  number_of_equations_per_cluster  10  valid elements per vector
//  element_width                    32  bits per element
//  no_of_units                      8   elements per beat
//  additional   no_of_units-(number_of_equations_per_cluster%no_of_units)  pad elements (derived)
//  total        number_of_equations_per_cluster+additional                padded length (derived, 16)
//  DEPTH        total/no_of_units                                         beats per bank (derived, 2)
// PORTS
//  clk        in   1                          clock, rising edge
//  reset      in   1                          asynchronous, active-low
//  wr_en      in   1                          write beat valid (ALU result_mem_we_*)
//  wr_data    in   element_width*no_of_units  write beat; lane 0 in bits [element_width-1:0]
//  rd_req     in   1                          one-cycle pulse: read next sequential beat
//  rd_addr    in   32                         beat index for the addressed read port (rkold_read_address)
//  swap       in   1                          one-cycle pulse: exchange write and read banks
//  rd_data    out  element_width*no_of_units  sequential read data
//  rd_valid   out  1                          rd_data valid, one-cycle pulse
//  rd_data_a  out  element_width*no_of_units  addressed read data, registered
//  wr_done    out  1                          pulse when beat DEPTH-1 of the write bank is written
//  rd_done    out  1                          pulse coincident with rd_valid of beat DEPTH-1
//  wr_full    out  1                          write bank holds DEPTH beats
//  err        out  1                          sticky: overflow write or premature swap
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//   - All outputs go to 0, including rd_data and rd_data_a.
//   - Bank select goes to 0 (write to bank 0, read from bank 1). Both pointers go to 0.
//   - Memory contents are undefined unless CG_ZERO_PAD_EN is defined.
//  Write FSM: FILL -> FULL -> FILL.
//   - In FILL, wr_en writes wr_data to wbank[wr_ptr] and then wr_ptr++.
//   - On the write with wr_ptr==DEPTH-1: wr_done=1 for 1 cycle, wr_full=1, go to FULL.
//   - In FULL, wr_en is dropped (memory unchanged) and err=1.
//  Sequential read:
//   - rd_req=1 in cycle N gives rd_data=rbank[rd_ptr] and rd_valid=1 in cycle N+1. Then rd_ptr++.
//   - At DEPTH-1, rd_done=1 together with rd_valid and rd_ptr wraps to 0.
//   - Back-to-back rd_req gives 1 beat per cycle.
//  Addressed read:
//   - rd_data_a = rbank[rd_addr mod DEPTH], registered every cycle (1-cycle latency), no handshake.
//  Swap:
//   - Honoured in FULL only. On the next edge: bank select toggles, wr_ptr=0, rd_ptr=0,
//     wr_full=0, FSM goes to FILL.
//   - Swap in FILL is ignored and sets err=1.
//  Simultaneous events:
//   - swap+wr_en in the same cycle in FULL: the write is dropped, err=1, swap happens.
//   - swap+rd_req in the same cycle: the read uses the pre-swap bank and pointer. Its rd_valid beat
//     still comes out in the next cycle. rd_ptr is then forced to 0.
//   - wr_en+rd_req always proceed in parallel (separate banks, no hazard).
//  err is cleared only by reset.
//  Reset mid-burst: the partial write is abandoned. The pending rd_valid is cancelled.
// CONFIGURATION
//  CG_ZERO_PAD_EN defined:
//   - On the write of beat DEPTH-1, lanes at index >= number_of_equations_per_cluster-(DEPTH-1)*no_of_units
//     are stored as 0, whatever wr_data holds. Pad elements therefore add nothing to r.r or p.Ap.
//   - Reset also clears both banks to 0.
//  CG_ZERO_PAD_EN undefined:
//   - wr_data is stored verbatim. Memory is not cleared on reset.
// TESTING (defaults: DEPTH=2, 32-bit lanes)
//  1 Reset, write beats A0,A1 (lane k = 32'h3F800000+k), swap, 2x rd_req
//    -> rd_data A0 then A1 on consecutive cycles; rd_done with A1; wr_done one cycle after the A1 write.
//  2 Write 2 beats, then a 3rd wr_en with 32'hDEADBEEF lanes
//    -> err=1; after swap the reads return the first 2 beats unchanged.
//  3 Swap after 1 write beat -> err=1; bank not swapped; reads still return prior read-bank data.
//  4 Full bank, swap and rd_req in the same cycle -> rd_data = old-bank beat; next rd_req returns new beat 0.
//  5 CG_ZERO_PAD_EN: write beat 1 with all lanes 32'hFFFFFFFF, swap, read
//    -> lanes 0-1 = 32'hFFFFFFFF, lanes 2-7 = 0; without the macro all lanes = 32'hFFFFFFFF.
//  6 Reset (reset=0) asserted mid-burst while rd_req is pending
//    -> rd_valid=0 and err=0 asynchronously; the next write goes to bank 0, beat 0.

Source files
------------

// File: rtl/cg_vector_bank.sv
// cg_vector_bank: double-buffered CG vector store, sequential and addressed read ports.
// Optional CG_ZERO_PAD_EN: zero pad lanes of the last beat and clear both banks on reset.
module cg_vector_bank #(
  parameter int number_of_equations_per_cluster = 10,
  parameter int element_width = 32,
  parameter int no_of_units = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 wr_en,
  input  logic [element_width*no_of_units-1:0] wr_data,
  input  logic                                 rd_req,
  input  logic [31:0]                          rd_addr,
  input  logic                                 swap,
  output logic [element_width*no_of_units-1:0] rd_data,
  output logic                                 rd_valid,
  output logic [element_width*no_of_units-1:0] rd_data_a,
  output logic                                 wr_done,
  output logic                                 rd_done,
  output logic                                 wr_full,
  output logic                                 err
);
  localparam int additional = no_of_units - (number_of_equations_per_cluster % no_of_units);
  localparam int total = number_of_equations_per_cluster + additional;
  localparam int DEPTH = total / no_of_units;
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int BW = element_width * no_of_units;
  typedef enum logic {FILL, FULL} state_t;
  state_t state;
  logic sel;
  logic [PW-1:0] wr_ptr, rd_ptr, a_idx;
  logic [BW-1:0] mem [2][DEPTH];
  logic [BW-1:0] wr_word;
  logic wr_go, wr_last, rd_last, swap_go;
  always_comb begin
    wr_go = wr_en && state == FILL;
    wr_last = wr_ptr == PW'(DEPTH - 1);
    rd_last = rd_ptr == PW'(DEPTH - 1);
    swap_go = swap && state == FULL;
    a_idx = PW'(rd_addr % DEPTH);
    wr_word = wr_data;
`ifdef CG_ZERO_PAD_EN
    for (int k = number_of_equations_per_cluster - (DEPTH - 1) * no_of_units; k < no_of_units; k++)
      if (wr_last) wr_word[k*element_width +: element_width] = '0;
`endif
  end
  // sel names the write bank; the read bank is always the other one
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= FILL;
      sel <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      rd_data_a <= '0;
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      wr_full <= 1'b0;
      err <= 1'b0;
    end else begin
      wr_done <= wr_go && wr_last;
      rd_valid <= rd_req;
      rd_done <= rd_req && rd_last;
      rd_data_a <= mem[~sel][a_idx];
      if (rd_req) rd_data <= mem[~sel][rd_ptr];
      if ((wr_en && state == FULL) || (swap && state == FILL)) err <= 1'b1;
      if (swap_go) begin
        state <= FILL;
        sel <= ~sel;
        wr_ptr <= '0;
        rd_ptr <= '0;
        wr_full <= 1'b0;
      end else begin
        if (rd_req) rd_ptr <= rd_last ? '0 : rd_ptr + 1'b1;
        if (wr_go) begin
          wr_ptr <= wr_last ? wr_ptr : wr_ptr + 1'b1;
          wr_full <= wr_last;
          state <= wr_last ? FULL : FILL;
        end
      end
    end
`ifdef CG_ZERO_PAD_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int b = 0; b < 2; b++)
        for (int d = 0; d < DEPTH; d++) mem[b][d] <= '0;
    end else if (wr_go) mem[sel][wr_ptr] <= wr_word;
`else
  always_ff @(posedge clk)
    if (wr_go) mem[sel][wr_ptr] <= wr_word;
`endif
endmodule

// File: tb/tb_cg_vector_bank.sv
// tb_cg_vector_bank: directed scenarios plus random traffic against a queue-based bank model.
module tb_cg_vector_bank;
  localparam int N = 10, EW = 32, U = 8, DEPTH = 2, BW = EW * U;
  logic clk = 0, reset = 0, wr_en = 0, rd_req = 0, swap = 0;
  logic [BW-1:0] wr_data = '0;
  logic [31:0] rd_addr = '0;
  logic [BW-1:0] rd_data, rd_data_a;
  logic rd_valid, wr_done, rd_done, wr_full, err;
  int checks = 0, failures = 0;
  cg_vector_bank dut (.clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_req(rd_req),
    .rd_addr(rd_addr), .swap(swap), .rd_data(rd_data), .rd_valid(rd_valid), .rd_data_a(rd_data_a),
    .wr_done(wr_done), .rd_done(rd_done), .wr_full(wr_full), .err(err));
  always #5 clk = ~clk;
  logic [BW-1:0] wq[$];
  logic [BW-1:0] rb[DEPTH];
  bit rbk[DEPTH];
  int rptr;
  bit full_m, err_m;
  logic [BW-1:0] e_rd, e_a;
  bit e_rdk, e_ak, e_valid, e_done, e_wdone;
  function automatic logic [BW-1:0] padded(input logic [BW-1:0] d, input int beat);
    padded = d;
`ifdef CG_ZERO_PAD_EN
    for (int k = 0; k < U; k++) if (beat * U + k >= N) padded[k*EW +: EW] = '0;
`endif
  endfunction
  function automatic logic [BW-1:0] rnd_beat();
    for (int k = 0; k < U; k++) rnd_beat[k*EW +: EW] = $urandom;
  endfunction
  function automatic logic [BW-1:0] seq_beat(input logic [31:0] base);
    for (int k = 0; k < U; k++) seq_beat[k*EW +: EW] = base + k;
  endfunction
  task automatic model_reset();
    wq.delete();
    full_m = 0; err_m = 0; rptr = 0;
    e_rd = '0; e_a = '0; e_rdk = 1; e_ak = 1; e_valid = 0; e_done = 0; e_wdone = 0;
    for (int i = 0; i < DEPTH; i++) begin
      rb[i] = '0;
`ifdef CG_ZERO_PAD_EN
      rbk[i] = 1;
`else
      rbk[i] = 0;
`endif
    end
  endtask
  task automatic cycle(input logic w, input logic [BW-1:0] d, input logic r, input logic [31:0] a,
                       input logic s);
    int ai;
    wr_en = w; wr_data = d; rd_req = r; rd_addr = a; swap = s;
    @(posedge clk); #1;
    e_valid = r;
    e_done = r && rptr == DEPTH - 1;
    if (r) begin
      e_rd = rb[rptr]; e_rdk = rbk[rptr];
      rptr = (rptr + 1) % DEPTH;
    end
    ai = int'(a % DEPTH);
    e_a = rb[ai]; e_ak = rbk[ai];
    e_wdone = 0;
    if (w) begin
      if (full_m) err_m = 1;
      else begin
        wq.push_back(padded(d, wq.size()));
        e_wdone = wq.size() == DEPTH;
      end
    end
    if (s) begin
      if (!full_m) err_m = 1;
      else begin
        for (int i = 0; i < DEPTH; i++) begin rb[i] = wq[i]; rbk[i] = 1; end
        wq.delete();
        rptr = 0;
      end
    end
    full_m = wq.size() == DEPTH;
    wr_en = 0; rd_req = 0; swap = 0;
  endtask
  task automatic do_reset();
    reset = 0;
    @(posedge clk); #1;
    reset = 1;
    model_reset();
  endtask
  task automatic test_reset();
    reset = 0;
    #12;
    checks++; if ({rd_valid, rd_done, wr_done, wr_full, err} !== 5'b0) begin failures++;
      $display("FAIL reset_flags got %b want 00000", {rd_valid, rd_done, wr_done, wr_full, err}); end
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    checks++; if (rd_data_a !== '0) begin failures++; $display("FAIL reset_rd_data_a got %h want 0", rd_data_a); end
    @(posedge clk); #1;
    reset = 1;
    model_reset();
  endtask
  task automatic test_basic();
    do_reset();
    cycle(1, seq_beat(32'h3F800000), 0, 0, 0);
    checks++; if (wr_done !== 1'b0 || wr_full !== 1'b0) begin failures++;
      $display("FAIL basic_a0 wr_done/wr_full got %b%b want 00", wr_done, wr_full); end
    cycle(1, seq_beat(32'h3F800008), 0, 0, 0);
    checks++; if (wr_done !== e_wdone || wr_full !== full_m) begin failures++;
      $display("FAIL basic_a1 wr_done/wr_full got %b%b want %b%b", wr_done, wr_full, e_wdone, full_m); end
    cycle(0, '0, 0, 0, 1);
    checks++; if (wr_done !== 1'b0 || wr_full !== 1'b0) begin failures++;
      $display("FAIL basic_swap wr_done/wr_full got %b%b want 00", wr_done, wr_full); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, '0, 1, 0, 0);
      checks++; if (rd_valid !== 1'b1 || rd_done !== e_done || rd_data !== e_rd) begin failures++;
        $display("FAIL basic_read%0d valid=%b done=%b data=%h want 1 %b %h", i, rd_valid, rd_done, rd_data, e_done, e_rd); end
    end
    cycle(0, '0, 0, 0, 0);
    checks++; if (rd_valid !== 1'b0 || rd_done !== 1'b0) begin failures++;
      $display("FAIL basic_idle valid/done got %b%b want 00", rd_valid, rd_done); end
  endtask
  task automatic test_overflow();
    do_reset();
    cycle(1, rnd_beat(), 0, 0, 0);
    cycle(1, rnd_beat(), 0, 0, 0);
    cycle(1, {U{32'hDEADBEEF}}, 0, 0, 0);
    checks++; if (err !== 1'b1 || wr_full !== 1'b1) begin failures++;
      $display("FAIL overflow err/wr_full got %b%b want 11", err, wr_full); end
    cycle(0, '0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, '0, 1, 0, 0);
      checks++; if (rd_data !== e_rd) begin failures++;
        $display("FAIL overflow_read%0d got %h want %h", i, rd_data, e_rd); end
    end
  endtask
  task automatic test_early_swap();
    do_reset();
    cycle(1, rnd_beat(), 0, 0, 0);
    cycle(1, rnd_beat(), 0, 0, 0);
    cycle(0, '0, 0, 0, 1);
    cycle(1, rnd_beat(), 0, 0, 0);
    cycle(0, '0, 0, 0, 1);
    checks++; if (err !== 1'b1 || wr_full !== 1'b0) begin failures++;
      $display("FAIL early_swap err/wr_full got %b%b want 10", err, wr_full); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, '0, 1, i, 0);
      checks++; if (rd_data !== e_rd) begin failures++;
        $display("FAIL early_swap_read%0d got %h want %h", i, rd_data, e_rd); end
    end
    cycle(1, rnd_beat(), 0, 1, 0);
    checks++; if (wr_full !== 1'b1 || rd_data_a !== e_a) begin failures++;
      $display("FAIL early_swap_fill wr_full=%b rd_data_a=%h want 1 %h", wr_full, rd_data_a, e_a); end
  endtask
  task automatic test_swap_read();
    cycle(0, '0, 1, 0, 1);
    checks++; if (rd_valid !== 1'b1 || rd_data !== e_rd) begin failures++;
      $display("FAIL swap_read_old valid=%b data=%h want 1 %h", rd_valid, rd_data, e_rd); end
    cycle(0, '0, 1, 0, 0);
    checks++; if (rd_data !== e_rd || rd_done !== 1'b0) begin failures++;
      $display("FAIL swap_read_new data=%h done=%b want %h 0", rd_data, rd_done, e_rd); end
  endtask
  task automatic test_pad();
    logic [BW-1:0] want;
    do_reset();
    cycle(1, rnd_beat(), 0, 0, 0);
    cycle(1, {U{32'hFFFFFFFF}}, 0, 0, 0);
    cycle(0, '0, 0, 0, 1);
    cycle(0, '0, 1, 0, 0);
    cycle(0, '0, 1, 0, 0);
    want = {U{32'hFFFFFFFF}};
`ifdef CG_ZERO_PAD_EN
    want[BW-1:2*EW] = '0;
`endif
    checks++; if (rd_data !== want) begin failures++;
      $display("FAIL pad_beat got %h want %h", rd_data, want); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    cycle(1, rnd_beat(), 0, 0, 1);
    cycle(0, '0, 1, 0, 0);
    checks++; if (rd_valid !== 1'b1 || err !== 1'b1) begin failures++;
      $display("FAIL mid_pre valid/err got %b%b want 11", rd_valid, err); end
    #1 reset = 0;
    #1;
    checks++; if (rd_valid !== 1'b0 || err !== 1'b0 || wr_full !== 1'b0) begin failures++;
      $display("FAIL mid_async valid/err/full got %b%b%b want 000", rd_valid, err, wr_full); end
    @(posedge clk); #1;
    reset = 1;
    model_reset();
    cycle(1, seq_beat(32'h100), 0, 0, 0);
    cycle(1, seq_beat(32'h200), 0, 0, 0);
    cycle(0, '0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, '0, 1, i + 2, 0);
      checks++; if (rd_data !== e_rd || rd_data_a !== e_a) begin failures++;
        $display("FAIL mid_read%0d data=%h a=%h want %h %h", i, rd_data, rd_data_a, e_rd, e_a); end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 0) do_reset();
      cycle($urandom_range(0, 1), rnd_beat(), $urandom_range(0, 1), $urandom, $urandom_range(0, 4) == 0);
      checks++; if ({rd_valid, rd_done, wr_done, wr_full, err} !== {e_valid, e_done, e_wdone, full_m, err_m}) begin
        failures++; $display("FAIL rand_flags cyc %0d got %b want %b", i,
          {rd_valid, rd_done, wr_done, wr_full, err}, {e_valid, e_done, e_wdone, full_m, err_m}); end
      if (e_rdk) begin
        checks++; if (rd_data !== e_rd) begin failures++;
          $display("FAIL rand_rd_data cyc %0d got %h want %h", i, rd_data, e_rd); end
      end
      if (e_ak) begin
        checks++; if (rd_data_a !== e_a) begin failures++;
          $display("FAIL rand_rd_data_a cyc %0d got %h want %h", i, rd_data_a, e_a); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_early_swap();
    test_swap_read();
    test_pad();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
